mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit; consumes the EX/MEM pipeline register outputs (the *M bundle) and produces the MEM/WB bundle (*W).
- Drives a multi-cycle data-memory request/response bus, aligns and sign/zero-extends load data, and generates byte enables for stores.
- Asserts StallM to freeze the upstream pipeline while an access is in flight.

Parameters:
- XLEN, 32, data/address width
- REG_AW, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ValidM  in  1  the *M bundle holds a real instruction
- RegWriteM  in  1  instruction writes rd
- ResultSrcM  in  1  1 = load (result from memory)
- MemWriteM  in  1  store
- Funct3M  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ALUResultM  in  32  effective address, or ALU result
- WriteDataM  in  32  store data (unaligned, LSB-justified)
- RdM  in  5  destination register
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-shifted store data
- mem_be  out  4  byte enables
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- StallM  out  1  hold EX/MEM register and all earlier stages
- RegWriteW  out  1  registered; 0 on bubbles
- ResultSrcW  out  1  registered
- ALUResultW  out  32  registered
- ReadDataW  out  32  registered, extended load data
- RdW  out  5  registered
- MisalignW  out  1  registered; misaligned access trapped

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req=0; all *W outputs 0; MisalignW=0; StallM=0.
- mem op = ValidM & (ResultSrcM | MemWriteM). Misaligned = H with addr[0]=1, or W with addr[1:0]!=0.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE, no mem op: next edge *W <= *M bundle (RegWriteW = RegWriteM & ValidM); latency 1; StallM=0.
- IDLE, misaligned mem op: no bus activity; next edge RegWriteW=0, MisalignW=1, RdW/ALUResultW captured; StallM=0.
- IDLE, aligned mem op: StallM=1 combinationally; latch addr/wdata/be/we/funct3/rd into internal regs; ->REQ; *W loads a bubble (RegWriteW=0).
- REQ: mem_req=1 with stable addr/we/wdata/be until mem_gnt. Store + gnt: ->IDLE, *W loads the store (RegWriteW=0, MisalignW=0); StallM drops this cycle. Load + gnt: ->WAIT_RSP. StallM=1 except on a store-grant cycle.
- WAIT_RSP: mem_req=0; StallM=1 except on the rvalid cycle. On mem_rvalid, ->IDLE and *W loads with ReadDataW = extended data.
- mem_rvalid in the same cycle as mem_gnt is legal: a load completes directly from REQ. The bus guarantees rvalid no earlier than the gnt cycle.
- Lane rules: B: mem_be = 1<<addr[1:0], wdata = {4{WriteDataM[7:0]}}. H: be = addr[1] ? 1100 : 0011, wdata = {2{WriteDataM[15:0]}}. W: be = 1111.
- Load extraction selects the byte/half by latched addr[1:0]. B/H are sign-extended; BU/HU are zero-extended.
- mem_be is 0000 for loads.
- Stall semantics: while StallM=1 the *M inputs are held by upstream; the block samples them only in IDLE.
- Every non-completing cycle is a bubble (RegWriteW=0), so there is no duplicate write-back.
- Reset mid-operation: state returns to IDLE immediately and any outstanding transaction is abandoned. The bus side is reset together with this block.

Decomposition:
- Shared package (lsu_pkg): Funct3 size encodings as constants, lsu_state_t enum {IDLE, REQ, WAIT_RSP}, XLEN.
- One natural combinational sub-module, lsu_align: store lane shift/byte-enable generation and load extract/extend; instantiated once for the store path and once for the load path.

Test Plan:
- Non-mem ALU op, RegWriteM=1, ALUResultM=0x0000_1234, RdM=5 -> next edge RegWriteW=1, ALUResultW=0x1234, RdW=5; StallM never high.
- SW addr 0x100, data 0xDEADBEEF, gnt after 2 wait cycles -> mem_req held 3 cycles; mem_addr=0x100, be=1111, wdata=0xDEADBEEF; StallM high 3 cycles; RegWriteW stays 0.
- LB addr 0x203, mem_rdata=0x80_00_00_00, rvalid 2 cycles after gnt -> mem_addr=0x200; ReadDataW=0xFFFFFF80, RegWriteW=1 for exactly one cycle. Repeat with LBU -> 0x00000080.
- SH addr 0x12, data 0x0000ABCD -> be=1100, wdata=0xABCDABCD. LH addr 0x12 with rdata 0xABCD0000 -> ReadDataW=0xFFFFABCD.
- LW addr 0x102 -> no mem_req, MisalignW=1, RegWriteW=0, no stall.
- Load with gnt and rvalid in the same cycle -> completes in 2 cycles total. rst_n pulsed low in WAIT_RSP -> outputs immediately 0, state IDLE; the next op proceeds normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   XLEN / REG_AW : default data and register-index widths
//   SZ_*          : size field (funct3[1:0]); funct3[2] selects zero-extension
//   lsu_state_t   : access sequencer states
//   is_misaligned : trap check for an access size against the low address bits
package lsu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data-memory bus (purely combinational).
//   funct3     : access size/sign
//   addr_lo    : byte offset within the word
//   store_data : LSB-justified store data
//   load_word  : raw word returned by memory
//   be         : byte enables for a store of this size/offset
//   lane_data  : store data replicated onto every lane it may occupy
//   load_data  : selected byte/half, sign- or zero-extended
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [3:0]      be,
    output logic [XLEN-1:0] lane_data,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = load_word[7:0];
            2'd1:    byte_sel = load_word[15:8];
            2'd2:    byte_sel = load_word[23:16];
            default: byte_sel = load_word[31:24];
        endcase
        half_sel = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    end

    always_comb begin
        be        = 4'b1111;
        lane_data = store_data;
        load_data = load_word;
        case (funct3[1:0])
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                lane_data = {4{store_data[7:0]}};
                load_data = funct3[2] ? {{(XLEN-8){1'b0}}, byte_sel}
                                      : {{(XLEN-8){byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{store_data[15:0]}};
                load_data = funct3[2] ? {{(XLEN-16){1'b0}}, half_sel}
                                      : {{(XLEN-16){half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns the EX/MEM bundle (*M) into the
// MEM/WB bundle (*W), running loads/stores over a request/grant +
// read-valid data bus and stalling upstream while an access is in flight.
//   *M inputs  : EX/MEM pipeline register outputs
//   mem_*      : data-memory request (req/we/addr/wdata/be) and response (gnt/rvalid/rdata)
//   StallM     : freeze EX/MEM and all earlier stages
//   *W outputs : registered MEM/WB bundle; RegWriteW=0 on bubbles
//
// state    | meaning
// IDLE     | sampling *M; non-memory ops and misaligned traps retire here
// REQ      | mem_req held with latched address/data until mem_gnt
// WAIT_RSP | load granted, waiting for mem_rvalid
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic              ResultSrcM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic [REG_AW-1:0] RdM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              StallM,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [REG_AW-1:0] RdW,
    output logic              MisalignW
);

    lsu_state_t state, state_next;

    logic mem_op, misalign, start, complete;

    logic [XLEN-1:0]   addr_q, wdata_q;
    logic [3:0]        be_q;
    logic              we_q, regwrite_q, result_src_q;
    logic [2:0]        funct3_q;
    logic [REG_AW-1:0] rd_q;

    logic [3:0]      st_be;
    logic [XLEN-1:0] st_lane, ld_data;
    logic [XLEN-1:0] st_load_unused, ld_lane_unused;
    logic [3:0]      ld_be_unused;

    assign mem_op   = ValidM & (ResultSrcM | MemWriteM);
    assign misalign = mem_op & is_misaligned(Funct3M, ALUResultM[1:0]);
    assign start    = mem_op & ~misalign;

    // A store finishes on its grant; a load on rvalid, which may coincide with the grant.
    assign complete = ((state == REQ) & mem_gnt & (we_q | mem_rvalid)) |
                      ((state == WAIT_RSP) & mem_rvalid);

    lsu_align #(.XLEN(XLEN)) u_store_align (
        .funct3     (Funct3M),
        .addr_lo    (ALUResultM[1:0]),
        .store_data (WriteDataM),
        .load_word  ('0),
        .be         (st_be),
        .lane_data  (st_lane),
        .load_data  (st_load_unused)
    );

    lsu_align #(.XLEN(XLEN)) u_load_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .store_data ('0),
        .load_word  (mem_rdata),
        .be         (ld_be_unused),
        .lane_data  (ld_lane_unused),
        .load_data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = REQ;
            REQ:      if (mem_gnt) state_next = (we_q | mem_rvalid) ? IDLE : WAIT_RSP;
            WAIT_RSP: if (mem_rvalid) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        StallM  = 1'b0;
        case (state)
            IDLE:     StallM = start;
            REQ: begin
                mem_req = 1'b1;
                StallM  = ~complete;
            end
            WAIT_RSP: StallM = ~mem_rvalid;
            default:  ;
        endcase
    end

    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

    // Access context is captured only when leaving IDLE; upstream holds *M while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            regwrite_q   <= 1'b0;
            result_src_q <= 1'b0;
            funct3_q     <= '0;
            rd_q         <= '0;
        end else if (state == IDLE && start) begin
            addr_q       <= ALUResultM;
            wdata_q      <= st_lane;
            be_q         <= MemWriteM ? st_be : 4'b0000;
            we_q         <= MemWriteM;
            regwrite_q   <= RegWriteM;
            result_src_q <= ResultSrcM & ~MemWriteM;
            funct3_q     <= Funct3M;
            rd_q         <= RdM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            MisalignW  <= 1'b0;
        end else if (state == IDLE && !start) begin
            // Non-memory op, empty slot, or trapped misaligned access.
            RegWriteW  <= RegWriteM & ValidM & ~misalign;
            ResultSrcW <= ResultSrcM & ValidM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= '0;
            RdW        <= RdM;
            MisalignW  <= misalign;
        end else if (complete) begin
            RegWriteW  <= regwrite_q & ~we_q;
            ResultSrcW <= result_src_q;
            ALUResultW <= addr_q;
            ReadDataW  <= we_q ? '0 : ld_data;
            RdW        <= rd_q;
            MisalignW  <= 1'b0;
        end else begin
            RegWriteW  <= 1'b0;
            MisalignW  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ValidM = 1'b0, RegWriteM = 1'b0, ResultSrcM = 1'b0, MemWriteM = 1'b0;
    logic [2:0]  Funct3M = '0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic [4:0]  RdM = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        StallM, RegWriteW, ResultSrcW, MisalignW;
    logic [31:0] ALUResultW, ReadDataW;
    logic [4:0]  RdW;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .MisalignW(MisalignW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rw, rsrc, mw;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        logic [4:0]  rd;
        int          gnt_dly, rv_dly;
        logic [31:0] rdata;
        logic        e_rw, e_mis;
        logic [31:0] e_rd, e_maddr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          e_req, e_stall;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(
        input logic valid, rw, rsrc, mw, input logic [2:0] f3,
        input logic [31:0] addr, wdata, input logic [4:0] rd,
        input int gnt_dly, rv_dly, input logic [31:0] rdata,
        input logic e_rw, e_mis, input logic [31:0] e_rd, e_maddr,
        input logic [3:0] e_be, input logic [31:0] e_wdata, input int e_req, e_stall);
        vec_t v;
        v.valid = valid; v.rw = rw; v.rsrc = rsrc; v.mw = mw; v.f3 = f3;
        v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.gnt_dly = gnt_dly; v.rv_dly = rv_dly; v.rdata = rdata;
        v.e_rw = e_rw; v.e_mis = e_mis; v.e_rd = e_rd; v.e_maddr = e_maddr;
        v.e_be = e_be; v.e_wdata = e_wdata; v.e_req = e_req; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives one instruction, plays the bus, and scores the retirement.
    task automatic run_op(input vec_t v);
        int  req_cnt, rv_cnt, n_req, n_stall, cyc;
        bit  granted, done;
        vec_t e;
        ValidM = v.valid; RegWriteM = v.rw; ResultSrcM = v.rsrc; MemWriteM = v.mw;
        Funct3M = v.f3; ALUResultM = v.addr; WriteDataM = v.wdata; RdM = v.rd;
        exp_q.push_back(v);
        req_cnt = 0; rv_cnt = 0; n_req = 0; n_stall = 0; cyc = 0; granted = 0; done = 0;
        while (!done && cyc < 40) begin
            #1;
            if (cyc > 0) check("bubble_regwrite", RegWriteW, 0);
            mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
            if (mem_req) begin
                n_req++;
                check("mem_addr", mem_addr, v.e_maddr);
                check("mem_we", mem_we, v.mw);
                check("mem_be", mem_be, v.e_be);
                if (v.mw) check("mem_wdata", mem_wdata, v.e_wdata);
                if (req_cnt == v.gnt_dly) begin
                    mem_gnt = 1; granted = 1; rv_cnt = 0;
                    if (!v.mw && v.rv_dly == 0) begin mem_rvalid = 1; mem_rdata = v.rdata; end
                end else begin
                    req_cnt++;
                end
            end else if (granted) begin
                rv_cnt++;
                if (rv_cnt == v.rv_dly) begin mem_rvalid = 1; mem_rdata = v.rdata; end
            end
            #1;
            if (StallM) n_stall++;
            else        done = 1;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        mem_gnt = 0; mem_rvalid = 0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL timeout: op at addr 0x%08h never retired, got %0d cycles expected <40", v.addr, cyc);
        end
        #1;
        e = exp_q.pop_front();
        check("RegWriteW", RegWriteW, e.e_rw);
        check("MisalignW", MisalignW, e.e_mis);
        check("RdW", RdW, e.rd);
        check("ALUResultW", ALUResultW, e.addr);
        if (e.valid && e.rsrc && !e.mw && !e.e_mis) check("ReadDataW", ReadDataW, e.e_rd);
        check("req_cycles", n_req, e.e_req);
        check("stall_cycles", n_stall, e.e_stall);
        ValidM = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("regwrite_one_cycle", RegWriteW, 0);
        check("misalign_one_cycle", MisalignW, 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            vld rw rs mw f3      addr          wdata         rd  g  r  rdata          e_rw mis e_rd          maddr         be       wdata         req stall
        vecs.push_back(mk(1, 1, 0, 0, 3'b000, 32'h0000_1234, 32'h0,         5, 0, 0, 32'h0,          1, 0, 32'h0,         32'h0,        4'h0,    32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'b010, 32'h0000_0100, 32'hDEADBEEF,  0, 2, 0, 32'h0,          0, 0, 32'h0,         32'h100,      4'hF,    32'hDEADBEEF,  3, 3));
        vecs.push_back(mk(1, 1, 1, 0, 3'b000, 32'h0000_0203, 32'h0,         7, 0, 2, 32'h8000_0000,  1, 0, 32'hFFFFFF80,  32'h200,      4'h0,    32'h0,         1, 3));
        vecs.push_back(mk(1, 1, 1, 0, 3'b100, 32'h0000_0203, 32'h0,         8, 0, 2, 32'h8000_0000,  1, 0, 32'h00000080,  32'h200,      4'h0,    32'h0,         1, 3));
        vecs.push_back(mk(1, 0, 0, 1, 3'b001, 32'h0000_0012, 32'h0000ABCD,  0, 1, 0, 32'h0,          0, 0, 32'h0,         32'h10,       4'hC,    32'hABCDABCD,  2, 2));
        vecs.push_back(mk(1, 1, 1, 0, 3'b001, 32'h0000_0012, 32'h0,         9, 0, 1, 32'hABCD_0000,  1, 0, 32'hFFFFABCD,  32'h10,       4'h0,    32'h0,         1, 2));
        vecs.push_back(mk(1, 1, 1, 0, 3'b010, 32'h0000_0102, 32'h0,         3, 0, 0, 32'h0,          0, 1, 32'h0,         32'h0,        4'h0,    32'h0,         0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 3'b010, 32'h0000_0040, 32'h0,        10, 0, 0, 32'h1234_5678,  1, 0, 32'h12345678,  32'h40,       4'h0,    32'h0,         1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 3'b000, 32'h0000_0301, 32'h000000A5,  0, 0, 0, 32'h0,          0, 0, 32'h0,         32'h300,      4'b0010, 32'hA5A5A5A5,  1, 1));
        vecs.push_back(mk(1, 1, 1, 0, 3'b101, 32'h0000_0002, 32'h0,        11, 1, 0, 32'h8001_0000,  1, 0, 32'h00008001,  32'h0,        4'h0,    32'h0,         2, 2));
        vecs.push_back(mk(0, 1, 0, 0, 3'b000, 32'h0000_0055, 32'h0,         4, 0, 0, 32'h0,          0, 0, 32'h0,         32'h0,        4'h0,    32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'b001, 32'h0000_0013, 32'h00001111,  0, 0, 0, 32'h0,          0, 1, 32'h0,         32'h0,        4'h0,    32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'b010, 32'h0000_0008, 32'h01234567,  0, 0, 0, 32'h0,          0, 0, 32'h0,         32'h8,        4'hF,    32'h01234567,  1, 1));
        vecs.push_back(mk(1, 1, 1, 0, 3'b000, 32'h0000_0001, 32'h0,        12, 0, 1, 32'h0000_7F00,  1, 0, 32'h0000007F,  32'h0,        4'h0,    32'h0,         1, 2));

        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_StallM", StallM, 0);
        check("rst_RegWriteW", RegWriteW, 0);
        check("rst_MisalignW", MisalignW, 0);
        check("rst_ReadDataW", ReadDataW, 0);
        check("rst_ALUResultW", ALUResultW, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

        // Reset while a load waits for its response: everything clears at once.
        ValidM = 1; RegWriteM = 1; ResultSrcM = 1; MemWriteM = 0;
        Funct3M = 3'b010; ALUResultM = 32'h80; WriteDataM = '0; RdM = 6;
        #1;
        check("rst_seq_idle_stall", StallM, 1);
        @(posedge clk); @(negedge clk); #1;
        check("rst_seq_req", mem_req, 1);
        mem_gnt = 1;
        #1;
        check("rst_seq_gnt_stall", StallM, 1);
        @(posedge clk); @(negedge clk);
        mem_gnt = 0;
        #1;
        check("rst_seq_wait_noreq", mem_req, 0);
        check("rst_seq_wait_stall", StallM, 1);
        ValidM = 0;
        rst_n = 0;
        #1;
        check("rst_seq_mem_req", mem_req, 0);
        check("rst_seq_StallM", StallM, 0);
        check("rst_seq_RegWriteW", RegWriteW, 0);
        check("rst_seq_ALUResultW", ALUResultW, 0);
        check("rst_seq_RdW", RdW, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run_op(mk(1, 1, 1, 0, 3'b010, 32'h0000_0044, 32'h0, 13, 0, 0, 32'hCAFE_F00D,
                  1, 0, 32'hCAFEF00D, 32'h44, 4'h0, 32'h0, 1, 1));
        run_op(mk(1, 1, 1, 0, 3'b001, 32'h0000_0046, 32'h0, 14, 2, 3, 32'h7FFF_0000,
                  1, 0, 32'h00007FFF, 32'h44, 4'h0, 32'h0, 3, 6));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
